key_event: RTL and testbench

Button gesture decoder that sits directly downstream of the key debouncer. It consumes the debounced level `btn_clean` and classifies each gesture as a single click, a double click or a long press. It also emits press and release strobes and keeps a wrapping event count for LED/seven-segment display logic. All outputs are registered single-clock-domain signals.

---
 rtl/key_event.sv | 109 ++++++++++
 tb/tb_key_event.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/key_event.sv
// Button gesture decoder: turns a debounced button level into press/release
// strobes plus click, double-click and long-press events with a wrapping count.
module key_event #(
  parameter int CNT_W    = 26,
  parameter int LONG_CYC = 50_000_000,
  parameter int DBL_CYC  = 25_000_000
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       btn_clean,
  output logic       press_pulse,
  output logic       release_pulse,
  output logic       click,
  output logic       double_click,
  output logic       long_press,
  output logic       held,
  output logic [7:0] evt_cnt
);

  typedef enum logic [2:0] {IDLE, PRESS1, LONG, WAIT2, PRESS2} state_t;

  localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
  localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_CYC - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             btn_d;
  logic             rise, fall;
  logic             press_n, rel_n, click_n, dbl_n, long_n, held_n;

  assign rise = btn_clean & ~btn_d;
  assign fall = ~btn_clean & btn_d;

  // btn_d resets high so a button held through reset never looks like a press.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state         <= IDLE;
      cnt           <= '0;
      btn_d         <= 1'b1;
      press_pulse   <= 1'b0;
      release_pulse <= 1'b0;
      click         <= 1'b0;
      double_click  <= 1'b0;
      long_press    <= 1'b0;
      held          <= 1'b0;
      evt_cnt       <= '0;
    end else begin
      state         <= state_nxt;
      cnt           <= cnt_nxt;
      btn_d         <= btn_clean;
      press_pulse   <= press_n;
      release_pulse <= rel_n;
      click         <= click_n;
      double_click  <= dbl_n;
      long_press    <= long_n;
      held          <= held_n;
      if (click_n | dbl_n | long_n)
        evt_cnt <= evt_cnt + 8'd1;
    end
  end

  // Edges take priority over the timer thresholds in PRESS1 and WAIT2.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (rise) state_nxt = PRESS1;
      PRESS1:  if (fall) state_nxt = WAIT2;
               else if (cnt == LONG_LAST) state_nxt = LONG;
      LONG:    if (fall) state_nxt = IDLE;
      WAIT2:   if (rise) state_nxt = PRESS2;
               else if (cnt == DBL_LAST) state_nxt = IDLE;
      PRESS2:  if (fall) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    cnt_nxt = cnt;
    if (state_nxt != state)
      cnt_nxt = '0;
    else if (state == PRESS1 || state == WAIT2)
      cnt_nxt = cnt + 1'b1;
  end

  always_comb begin
    press_n = 1'b0;
    rel_n   = 1'b0;
    click_n = 1'b0;
    dbl_n   = 1'b0;
    long_n  = 1'b0;
    case (state)
      IDLE:    press_n = rise;
      PRESS1:  begin
                 rel_n  = fall;
                 long_n = ~fall & (cnt == LONG_LAST);
               end
      LONG:    rel_n = fall;
      WAIT2:   begin
                 press_n = rise;
                 dbl_n   = rise;
                 click_n = ~rise & (cnt == DBL_LAST);
               end
      PRESS2:  rel_n = fall;
      default: ;
    endcase
    held_n = (state_nxt == PRESS1) || (state_nxt == LONG) || (state_nxt == PRESS2);
  end

endmodule

// File: tb/tb_key_event.sv
// Directed bench for key_event with CNT_W=4, LONG_CYC=8, DBL_CYC=5: a per-cycle
// vector table plus hand sequences for reset-hold, mid-gesture reset and wrap.
module tb_key_event;

  logic       clk = 1'b0;
  logic       rstn;
  logic       btn_clean;
  logic       press_pulse, release_pulse, click, double_click, long_press, held;
  logic [7:0] evt_cnt;

  int checks = 0;
  int errors = 0;

  key_event #(.CNT_W(4), .LONG_CYC(8), .DBL_CYC(5)) dut (
    .clk          (clk),
    .rstn         (rstn),
    .btn_clean    (btn_clean),
    .press_pulse  (press_pulse),
    .release_pulse(release_pulse),
    .click        (click),
    .double_click (double_click),
    .long_press   (long_press),
    .held         (held),
    .evt_cnt      (evt_cnt)
  );

  always #5 clk = ~clk;

  // {press, release, click, double, long, held}
  localparam logic [5:0] N = 6'b000000;
  localparam logic [5:0] P = 6'b100000;
  localparam logic [5:0] R = 6'b010000;
  localparam logic [5:0] C = 6'b001000;
  localparam logic [5:0] D = 6'b000100;
  localparam logic [5:0] L = 6'b000010;
  localparam logic [5:0] H = 6'b000001;

  typedef struct {
    logic       btn;
    logic [5:0] exp;
    logic [7:0] evt;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input logic b, input logic [5:0] e, input logic [7:0] ev, input int n);
    for (int i = 0; i < n; i++) vecs.push_back('{b, e, ev});
  endfunction

  task automatic chk(input string nm, input logic [5:0] e, input logic [7:0] ev);
    logic [5:0] obs;
    obs = {press_pulse, release_pulse, click, double_click, long_press, held};
    checks++;
    if (obs !== e || evt_cnt !== ev) begin
      errors++;
      $display("FAIL %s: got p/r/c/d/l/h=%b evt=%0d, expected %b evt=%0d", nm, obs, evt_cnt, e, ev);
    end
  endtask

  // Drive the input between edges, then sample just after the rising edge.
  task automatic step(input logic b);
    @(negedge clk);
    btn_clean = b;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rstn      = 1'b0;
    btn_clean = 1'b1;

    // click then idle
    add(0, N,     0, 1);
    add(1, P | H, 0, 1);
    add(1, H,     0, 2);
    add(0, R,     0, 1);
    add(0, N,     0, 4);
    add(0, C,     1, 1);
    add(0, N,     1, 1);
    // double click
    add(1, P | H,     1, 1);
    add(1, H,         1, 2);
    add(0, R,         1, 1);
    add(0, N,         1, 1);
    add(1, P | D | H, 2, 1);
    add(1, H,         2, 1);
    add(0, R,         2, 1);
    add(0, N,         2, 6);
    // long press, 20 cycles high
    add(1, P | H, 2, 1);
    add(1, H,     2, 7);
    add(1, L | H, 3, 1);
    add(1, H,     3, 11);
    add(0, R,     3, 1);
    add(0, N,     3, 6);
    // release on the long threshold, then re-press on the click timeout
    add(1, P | H,     3, 1);
    add(1, H,         3, 7);
    add(0, R,         3, 1);
    add(0, N,         3, 4);
    add(1, P | D | H, 4, 1);
    add(0, R,         4, 1);
    add(0, N,         4, 6);

    repeat (3) @(posedge clk);
    #1;
    chk("reset_state", N, 0);

    // button held through reset must not register as a press
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step(1'b1);
      chk("held_thru_reset", N, 0);
    end

    foreach (vecs[i]) begin
      step(vecs[i].btn);
      chk($sformatf("vec%0d", i), vecs[i].exp, vecs[i].evt);
    end

    // reset asserted mid-WAIT2 aborts the gesture silently
    step(1'b1); chk("mid_press", P | H, 4);
    step(1'b0); chk("mid_release", R, 4);
    step(1'b0);
    step(1'b0);
    @(negedge clk);
    rstn = 1'b0;
    #1;
    chk("async_reset", N, 0);
    @(negedge clk);
    rstn = 1'b1;
    for (int i = 0; i < 10; i++) begin
      step(1'b0);
      chk("no_click_after_reset", N, 0);
    end

    // 256 single clicks wrap the event counter back to zero
    for (int k = 1; k <= 256; k++) begin
      step(1'b1);
      step(1'b0);
      repeat (4) step(1'b0);
      step(1'b0);
      chk($sformatf("wrap_click%0d", k), C, 8'(k));
    end
    step(1'b0);
    chk("wrap_final", N, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
